// File: rtl/table_writer.sv
`default_nettype none
// ============================================================================
// Module   : table_writer (with helper table_writer_hash)
// Purpose  : Control-plane writer for the exact-match hash table. A request
//            carries a key (1..8 bytes) and a value (0..8 bytes). The key is
//            zero-padded beyond key_len and hashed. Key bytes and then value
//            bytes are written one byte per cycle into the slot at
//            LOGIC_START_ADDR + hash*LOGIC_ENTRY_LEN.
// Ports    : clk, rst (async, active-low)
//            start_i   level request, must drop after ready_o before reuse
//            key_i     key bytes, byte 0 in [63:56]; key_len_i (legal 1..8)
//            val_i     value bytes, byte 0 in [63:56]; val_len_i (legal 0..8)
//            mem_*_o   byte-wide write port (width fixed at 1)
//            ready_o   operation complete; err_o request rejected
//            val_addr_o address of first value byte (0 on error)
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// table_writer_hash : 8-bit rotate-xor hash over the 8 key bytes, byte 0
// first: h = rotl1(h) ^ byte, h starting at 0. One byte per cycle. o_ready
// rises once the result is valid and stays high while i_start stays high;
// dropping i_start returns the unit to idle.
// Ports: clk, rst (async, active-low), i_start, i_key[63:0], o_ready, o_hash[7:0]
// ----------------------------------------------------------------------------
module table_writer_hash (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [63:0] i_key,
  output logic        o_ready,
  output logic [7:0]  o_hash
);

  logic [63:0] r_key;
  logic [7:0]  r_h;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic        r_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key   <= '0;
      r_h     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else if (!i_start) begin
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else if (!r_busy && !r_ready) begin
      r_key  <= i_key;
      r_h    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_h   <= {r_h[6:0], r_h[7]} ^ r_key[63:56];
      r_key <= {r_key[55:0], 8'h00};
      r_cnt <= r_cnt + 3'd1;
      if (r_cnt == 3'd7) begin
        r_busy  <= 1'b0;
        r_ready <= 1'b1;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_hash  = r_h;

endmodule

// ----------------------------------------------------------------------------
module table_writer #(
  parameter int LOGIC_ENTRY_LEN  = 16,
  parameter int LOGIC_START_ADDR = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [63:0] key_i,
  input  logic [5:0]  key_len_i,
  input  logic [63:0] val_i,
  input  logic [3:0]  val_len_i,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_width_o,
  output logic [31:0] mem_data_o,
  output logic        ready_o,
  output logic        err_o,
  output logic [31:0] val_addr_o
);

  typedef enum logic [2:0] {
    FREE   = 3'd0,
    CHECK  = 3'd1,
    HASH   = 3'd2,
    WR_KEY = 3'd3,
    WR_VAL = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      r_state, w_next;

  logic [63:0] r_key, r_val;
  logic [5:0]  r_key_len;
  logic [3:0]  r_val_len;
  logic [2:0]  r_cnt;
  logic [31:0] r_base;
  logic        r_hash_start;

  logic        r_mem_ce, r_mem_we, r_ready, r_err;
  logic [31:0] r_mem_addr, r_mem_data, r_val_addr;

  logic [63:0] w_hash_key;
  logic        w_hash_ready;
  logic [7:0]  w_hash_val;
  logic [31:0] w_base;
  logic        w_illegal;
  logic        w_key_last, w_val_last;

  // Byte idx of a 64-bit word, byte 0 being the most significant.
  function automatic logic [7:0] byte_at(input logic [63:0] d, input logic [2:0] idx);
    logic [63:0] s;
    s = d << {idx, 3'b000};
    return s[63:56];
  endfunction

  // Bytes beyond key_len are zeroed so the hash matches the zero-padded
  // key the matcher hashes on lookup.
  always_comb begin
    w_hash_key = '0;
    for (int i = 0; i < 8; i++) begin
      if (6'(i) < r_key_len)
        w_hash_key[63-8*i -: 8] = r_key[63-8*i -: 8];
    end
  end

  table_writer_hash u_hash (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_hash_start),
    .i_key   (w_hash_key),
    .o_ready (w_hash_ready),
    .o_hash  (w_hash_val)
  );

  assign w_base = 32'(LOGIC_START_ADDR) + 32'(w_hash_val) * 32'(LOGIC_ENTRY_LEN);

  assign w_illegal = (r_key_len == 6'd0) || (r_key_len > 6'd8) || (r_val_len > 4'd8) ||
                     (({1'b0, r_key_len} + {3'b000, r_val_len}) > 7'(LOGIC_ENTRY_LEN));

  assign w_key_last = ({3'b000, r_cnt} == (r_key_len - 6'd1));
  assign w_val_last = ({1'b0, r_cnt} == (r_val_len - 4'd1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= FREE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FREE:   if (start_i) w_next = CHECK;
      CHECK:  w_next = w_illegal ? DONE : HASH;
      HASH:   if (w_hash_ready) w_next = WR_KEY;
      // With no value bytes the empty value phase is skipped entirely.
      WR_KEY: if (w_key_last) w_next = (r_val_len == 4'd0) ? DONE : WR_VAL;
      WR_VAL: if (w_val_last) w_next = DONE;
      DONE:   if (!start_i) w_next = FREE;
      default: w_next = FREE;
    endcase
  end

  // Datapath and registered outputs. The memory port is loaded on the edge
  // that enters (or advances within) a write state, so the byte shown on the
  // bus always corresponds to the current r_cnt and mem_ce_o drops on the
  // same edge that enters DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key        <= '0;
      r_val        <= '0;
      r_key_len    <= '0;
      r_val_len    <= '0;
      r_cnt        <= '0;
      r_base       <= '0;
      r_hash_start <= 1'b0;
      r_mem_ce     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_ready      <= 1'b0;
      r_err        <= 1'b0;
      r_val_addr   <= '0;
    end else begin
      unique case (r_state)
        FREE: begin
          if (start_i) begin
            r_key      <= key_i;
            r_val      <= val_i;
            r_key_len  <= key_len_i;
            r_val_len  <= val_len_i;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_val_addr <= '0;
          end
        end
        CHECK: begin
          if (w_illegal) begin
            r_err      <= 1'b1;
            r_ready    <= 1'b1;
            r_val_addr <= '0;
          end else begin
            r_hash_start <= 1'b1;
          end
        end
        HASH: begin
          if (w_hash_ready) begin
            r_hash_start <= 1'b0;
            r_base       <= w_base;
            r_cnt        <= '0;
            r_mem_ce     <= 1'b1;
            r_mem_we     <= 1'b1;
            r_mem_addr   <= w_base;
            r_mem_data   <= {24'b0, byte_at(r_key, 3'd0)};
          end
        end
        WR_KEY: begin
          if (w_key_last) begin
            if (r_val_len == 4'd0) begin
              r_mem_ce   <= 1'b0;
              r_mem_we   <= 1'b0;
              r_ready    <= 1'b1;
              r_val_addr <= r_base + 32'(r_key_len);
            end else begin
              r_cnt      <= '0;
              r_mem_addr <= r_base + 32'(r_key_len);
              r_mem_data <= {24'b0, byte_at(r_val, 3'd0)};
            end
          end else begin
            r_cnt      <= r_cnt + 3'd1;
            r_mem_addr <= r_base + 32'(r_cnt) + 32'd1;
            r_mem_data <= {24'b0, byte_at(r_key, r_cnt + 3'd1)};
          end
        end
        WR_VAL: begin
          if (w_val_last) begin
            r_mem_ce   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_ready    <= 1'b1;
            r_val_addr <= r_base + 32'(r_key_len);
          end else begin
            r_cnt      <= r_cnt + 3'd1;
            r_mem_addr <= r_base + 32'(r_key_len) + 32'(r_cnt) + 32'd1;
            r_mem_data <= {24'b0, byte_at(r_val, r_cnt + 3'd1)};
          end
        end
        DONE: begin
          // ready/err/val_addr hold until the next accepted request
        end
        default: begin
          r_hash_start <= 1'b0;
        end
      endcase
    end
  end

  assign mem_ce_o    = r_mem_ce;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_width_o = 4'd1;
  assign mem_data_o  = r_mem_data;
  assign ready_o     = r_ready;
  assign err_o       = r_err;
  assign val_addr_o  = r_val_addr;

endmodule
`default_nettype wire

// File: doc/table_writer.md
Name: table_writer

Overview:
- Control-plane writer for the exact-match hash table that the packet-path matcher reads.
- Takes a key (1–8 bytes) and a value (0–N bytes) and hashes the key with the shared `hash` unit.
- Writes key bytes, then value bytes, byte-wide into the entry slot at LOGIC_START_ADDR + hash*LOGIC_ENTRY_LEN.
- A later match on the same key therefore returns val_addr = slot base + key_len.

Parameters:
- LOGIC_ENTRY_LEN, 16, bytes per table slot (key + value).
- LOGIC_START_ADDR, 128, byte address of slot 0.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  request; level, must drop after ready_o before next request is accepted.
- key_i  in  64  key bytes, byte 0 = bits 63:56, byte 7 = bits 7:0.
- key_len_i  in  6  key length in bytes, legal 1..8.
- val_i  in  64  value bytes, byte 0 = bits 63:56.
- val_len_i  in  4  value length in bytes, legal 0..8.
- mem_ce_o  out  1  memory enable.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  32  byte address.
- mem_width_o  out  4  constant 1.
- mem_data_o  out  32  write data, byte in bits 7:0, bits 31:8 zero.
- ready_o  out  1  operation complete.
- err_o  out  1  request rejected (illegal lengths).
- val_addr_o  out  32  address of first value byte, or 0 on error.

Behaviour:
- Reset (rst=0, asynchronous):
  - mem_ce_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0.
  - ready_o=0, err_o=0, val_addr_o=0.
  - Internal hash_start=0, state FREE.
  - Reset mid-write aborts immediately; bytes already written stay in memory.
- States: FREE, CHECK, HASH, WR_KEY, WR_VAL, DONE.
- FREE, start_i=1 edge:
  - Latch key, val, key_len, val_len.
  - Clear ready_o, err_o, val_addr_o.
  - Go to CHECK.
- CHECK (1 cycle):
  - Illegal if key_len=0, key_len>8, val_len>8, or key_len+val_len>LOGIC_ENTRY_LEN.
  - Illegal -> err_o=1, ready_o=1, val_addr_o=0, DONE; no memory access occurs.
  - Legal -> hash_start=1, HASH.
- Hash key input:
  - Latched 64-bit key with bytes at index >= key_len forced to zero.
  - This matches the zero padding on the match side.
- HASH:
  - Hold hash_start=1 until hash_ready=1.
  - Then: hash_start=0, base = LOGIC_START_ADDR + hash_val*LOGIC_ENTRY_LEN (mod 2^32), cnt=0, WR_KEY.
- WR_KEY: one byte per cycle.
  - Registered mem_ce_o=1, mem_we_o=1, mem_addr_o=base+cnt, mem_data_o={24'b0, key byte cnt}.
  - After byte key_len-1 -> WR_VAL with cnt=0.
- WR_VAL: one byte per cycle.
  - mem_addr_o = base+key_len+cnt, data = value byte cnt.
  - val_len=0 -> WR_VAL issues no write and proceeds directly.
  - After the last byte -> DONE.
  - On entering DONE: mem_ce_o=0, mem_we_o=0, ready_o=1, val_addr_o=base+key_len.
- Write count and timing:
  - mem_ce_o is high for exactly key_len+val_len consecutive cycles.
  - Addresses are strictly ascending with no gaps.
- DONE:
  - ready_o, err_o, val_addr_o hold.
  - start_i=0 -> FREE; outputs still hold until the next accepted start.
- Request/busy rules:
  - start_i held high through DONE does not restart.
  - start_i changes while busy are ignored.
  - Input changes after acceptance have no effect.
- Collisions: the slot is overwritten unconditionally; no occupancy check.

Test Plan:
- Basic insert: key=0x0A0B0C0D_00000000, key_len=4, val=0x11223344_55000000, val_len=5; bench computes H with the hash model.
  - Required: 9 writes at 128+16H .. 128+16H+8, data 0A,0B,0C,0D,11,22,33,44,55.
  - Required: ready_o=1, val_addr_o=128+16H+4.
- Padding: key_len=2, key_i=0xAABBFFFF_FFFFFFFF.
  - Required: hash computed on 0xAABB0000_00000000.
  - Required: only bytes AA, BB written as key.
- Errors: key_len=0; key_len=9; key_len=8 with val_len=9.
  - Required: err_o=1, ready_o=1, val_addr_o=0, mem_ce_o never asserted.
- Zero-value insert: key_len=8, val_len=0.
  - Required: exactly 8 writes, val_addr_o=base+8.
- Handshake: start_i held high 20 cycles after ready_o.
  - Required: no second operation.
  - Drop start_i for 1 cycle, reassert -> new operation; ready_o clears on acceptance.
- Reset mid-write: assert rst=0 during WR_KEY byte 2.
  - Required: mem_ce_o=0 and ready_o=0 without waiting for a clock edge.
  - Required: after release, state FREE and the next request completes normally.
